button_press_decoder: RTL

BUTTON_PRESS_DECODER -- requirements
Module: button_press_decoder

---
 rtl/button_pkg.sv | 23 ++
 rtl/debounce_filter.sv | 59 +++++
 rtl/button_press_decoder.sv | 100 ++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared constants and FSM encoding for push-button handling on the 20 MHz board.
// Default cycle counts are derived here so every switch block agrees on timing.
package button_pkg;

  localparam int unsigned CLK_HZ      = 20_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;
  localparam int unsigned LONG_MS     = 1000;

  localparam int unsigned DEFAULT_DEBOUNCE_CYC = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned DEFAULT_LONG_CYC     = (CLK_HZ / 1000) * LONG_MS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;

  // Width of a counter that must hold 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer plus stability counter for one mechanical switch.
// level is the accepted pressed state (1 = pressed) regardless of pin polarity.
module debounce_filter
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int unsigned     DW       = cnt_width(DEBOUNCE_CYC);
  localparam logic [DW-1:0]   CNT_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic            IDLE_PIN = ACTIVE_LOW;

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;
  logic          sample;

  assign sample = sync2_q ^ ACTIVE_LOW;

  // Any sample agreeing with the accepted level restarts the stability window.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sample == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE_PIN;
      sync2_q <= IDLE_PIN;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/button_press_decoder.sv
// Classifies debounced presses into short (on release) and long (at threshold)
// events, and keeps a wrapping count of short presses.
module button_press_decoder
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
  parameter int unsigned LONG_CYC     = DEFAULT_LONG_CYC,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       short_press,
  output logic       long_press,
  output logic [7:0] press_count,
  output btn_state_e state_dbg
);

  localparam int unsigned   HW        = cnt_width(LONG_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_CYC - 2);

  logic          level_w;
  btn_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic [7:0]    count_q, count_d;

  debounce_filter #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_in),
    .level (level_w)
  );

  // Release is tested before the threshold so a simultaneous fall is a short press.
  // The long pulse registers on the edge where the hold count lands on LONG_CYC-1.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (level_w) begin
          state_d = ST_PRESSED;
          hold_d  = '0;
        end
      end
      ST_PRESSED: begin
        if (!level_w) begin
          short_d = 1'b1;
          count_d = count_q + 8'd1;
          state_d = ST_IDLE;
        end else if (hold_q == HOLD_PRE) begin
          long_d  = 1'b1;
          hold_d  = HOLD_LAST;
          state_d = ST_HELD;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_HELD: begin
        if (!level_w) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      short_q <= short_d;
      long_q  <= long_d;
      count_q <= count_d;
    end
  end

  assign btn_level   = level_w;
  assign short_press = short_q;
  assign long_press  = long_q;
  assign press_count = count_q;
  assign state_dbg   = state_q;

endmodule
